// File: rtl/draw_sequencer.sv
// Full-screen draw sequencer: walks H_PIX*V_PIX pixels and drives the datapath counter strobes and VGA plot.
// Latency: drawReq edge -> INIT next cycle, first plot two cycles after INIT, drawDone one cycle after FLUSH.
// Backpressure: hold=1 freezes pixel issue (no counter strobes); plot follows issue by one cycle regardless of hold.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   drawReq/drawSel/clearReq  start request, screen select and black-fill select (latched when accepted in IDLE)
//   hold                   stall pixel issue
//   screenDone             datapath end-of-screen flag, sampled in FLUSH
//   memorySel, black       latched select / black-fill, stable while busy
//   addressScreenCounterReset, xReset, yReset   counter clears
//   screenCountLoad, xCountUp, yCountUp         counter advances (one pixel issued)
//   plot                   VGA write strobe, one cycle behind issue (ROM read latency)
//   busy, drawDone, frameErr   status; frameErr is sticky until the next accepted draw
module draw_sequencer #(
  parameter int H_PIX = 160,
  parameter int V_PIX = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       drawReq,
  input  logic [4:0] drawSel,
  input  logic       clearReq,
  input  logic       hold,
  input  logic       screenDone,
  output logic [4:0] memorySel,
  output logic       black,
  output logic       addressScreenCounterReset,
  output logic       xReset,
  output logic       yReset,
  output logic       screenCountLoad,
  output logic       xCountUp,
  output logic       yCountUp,
  output logic       plot,
  output logic       busy,
  output logic       drawDone,
  output logic       frameErr
);

  localparam logic [14:0] LAST_PIX = 15'(H_PIX * V_PIX - 1);
  localparam logic [7:0]  LAST_COL = 8'(H_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [14:0] r_pix;
  logic [7:0]  r_col;
  logic [4:0]  r_mem_sel;
  logic        r_black;
  logic        r_plot;
  logic        r_frame_err;

  logic        w_issue;
  logic        w_last_col;

  // A pixel is issued in every DRAW cycle that is not stalled.
  assign w_issue    = (r_state == S_DRAW) && !hold;
  assign w_last_col = (r_col == LAST_COL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_pix       <= '0;
      r_col       <= '0;
      r_mem_sel   <= '0;
      r_black     <= 1'b0;
      r_plot      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // ROM data for an issued pixel is valid one cycle later, so plot trails issue.
      r_plot <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (drawReq) begin
            r_mem_sel   <= drawSel;
            r_black     <= clearReq;
            r_frame_err <= 1'b0;
            r_state     <= S_INIT;
          end
        end
        S_INIT: begin
          r_pix   <= '0;
          r_col   <= '0;
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          if (w_issue) begin
            r_col <= w_last_col ? 8'd0 : r_col + 8'd1;
            r_pix <= r_pix + 15'd1;
            if (r_pix == LAST_PIX) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // The datapath counters must agree that the last pixel closed the screen.
          if (!screenDone) begin
            r_frame_err <= 1'b1;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign memorySel                 = r_mem_sel;
  assign black                     = r_black;
  assign plot                      = r_plot;
  assign frameErr                  = r_frame_err;
  assign busy                      = (r_state != S_IDLE);
  assign drawDone                  = (r_state == S_DONE);
  assign addressScreenCounterReset = (r_state == S_INIT);
  assign yReset                    = (r_state == S_INIT);
  // x wraps at end of each row as well as at the start of the frame.
  assign xReset                    = (r_state == S_INIT) || (w_issue && w_last_col);
  assign screenCountLoad           = w_issue;
  assign xCountUp                  = w_issue && !w_last_col;
  assign yCountUp                  = w_issue && w_last_col;

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;

  localparam int H    = 160;
  localparam int V    = 120;
  localparam int NPIX = H * V;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       drawReq;
  logic       s_drawReq;
  logic [4:0] drawSel;
  logic       clearReq;
  logic       hold;
  logic       screenDone;

  logic [4:0] memorySel;
  logic       black, addrReset, xReset, yReset, scLoad, xUp, yUp;
  logic       plot, busy, drawDone, frameErr;

  logic [4:0] s_memorySel;
  logic       s_black, s_addrReset, s_xReset, s_yReset, s_scLoad, s_xUp, s_yUp;
  logic       s_plot, s_busy, s_drawDone, s_frameErr;

  draw_sequencer u_dut (
    .clk(clk), .resetn(resetn), .drawReq(drawReq), .drawSel(drawSel),
    .clearReq(clearReq), .hold(hold), .screenDone(screenDone),
    .memorySel(memorySel), .black(black), .addressScreenCounterReset(addrReset),
    .xReset(xReset), .yReset(yReset), .screenCountLoad(scLoad),
    .xCountUp(xUp), .yCountUp(yUp), .plot(plot), .busy(busy),
    .drawDone(drawDone), .frameErr(frameErr)
  );

  draw_sequencer #(.H_PIX(4), .V_PIX(2)) u_small (
    .clk(clk), .resetn(resetn), .drawReq(s_drawReq), .drawSel(drawSel),
    .clearReq(clearReq), .hold(hold), .screenDone(screenDone),
    .memorySel(s_memorySel), .black(s_black), .addressScreenCounterReset(s_addrReset),
    .xReset(s_xReset), .yReset(s_yReset), .screenCountLoad(s_scLoad),
    .xCountUp(s_xUp), .yCountUp(s_yUp), .plot(s_plot), .busy(s_busy),
    .drawDone(s_drawDone), .frameErr(s_frameErr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-run observation counters.
  int cyc, n_plot, n_x, n_y, n_done, done_cyc, first_plot, first_load;
  int s_nplot, s_ndone, s_first_done, s_last_done;

  // Behavioural model: pixels issued so far, plus where we are in the draw lifecycle.
  bit       m_busy, m_init, m_plot, m_ferr, m_black;
  logic [4:0] m_sel;
  int       m_n;
  int       m_tail;   // 2: flush cycle, 1: done cycle, 0: otherwise

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_init = 0; m_plot = 0; m_ferr = 0; m_black = 0;
    m_sel = '0; m_n = 0; m_tail = 0;
  endtask

  task automatic model_update();
    if (!resetn) begin
      model_reset();
    end else if (!m_busy) begin
      m_plot = 0;
      if (drawReq) begin
        m_busy = 1; m_init = 1; m_sel = drawSel; m_black = clearReq; m_ferr = 0; m_n = 0;
      end
    end else if (m_init) begin
      m_init = 0; m_plot = 0;
    end else if (m_tail == 0) begin
      m_plot = !hold;
      if (!hold) begin
        m_n++;
        if (m_n == NPIX) m_tail = 2;
      end
    end else if (m_tail == 2) begin
      if (!screenDone) m_ferr = 1;
      m_plot = 0; m_tail = 1;
    end else begin
      m_tail = 0; m_busy = 0; m_plot = 0;
    end
  endtask

  // One clock: compare everything at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit drawing, issue, last_col;
    @(negedge clk);
    drawing  = m_busy && !m_init && (m_tail == 0);
    issue    = drawing && !hold;
    last_col = ((m_n % H) == H - 1);
    check("busy",        busy,      m_busy);
    check("addrReset",   addrReset, m_init);
    check("yReset",      yReset,    m_init);
    check("xReset",      xReset,    m_init || (issue && last_col));
    check("screenLoad",  scLoad,    issue);
    check("xCountUp",    xUp,       issue && !last_col);
    check("yCountUp",    yUp,       issue && last_col);
    check("plot",        plot,      m_plot);
    check("drawDone",    drawDone,  m_tail == 1);
    check("frameErr",    frameErr,  m_ferr);
    check("memorySel",   memorySel, m_sel);
    check("black",       black,     m_black);
    if (plot) begin n_plot++; if (first_plot == 0) first_plot = cyc; end
    if (scLoad && first_load == 0) first_load = cyc;
    if (xUp) n_x++;
    if (yUp) n_y++;
    if (drawDone) begin n_done++; done_cyc = cyc; end
    if (s_plot) s_nplot++;
    if (s_drawDone) begin
      s_ndone++; s_last_done = cyc;
      if (s_first_done == 0) s_first_done = cyc;
    end
    @(posedge clk);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic clear_counts();
    cyc = 0; n_plot = 0; n_x = 0; n_y = 0; n_done = 0; done_cyc = 0;
    first_plot = 0; first_load = 0;
    s_nplot = 0; s_ndone = 0; s_first_done = 0; s_last_done = 0;
  endtask

  initial begin
    clear_counts();
    resetn = 0; drawReq = 0; s_drawReq = 0; drawSel = 5'd0; clearReq = 0;
    hold = 0; screenDone = 0;
    model_reset();
    tick();
    tick();
    check("rst_memorySel", memorySel, 0);
    check("rst_busy",      busy,      0);
    check("rst_plot",      plot,      0);
    check("rst_frameErr",  frameErr,  0);
    resetn = 1;
    tick();

    // Small screen: back-to-back draws with drawReq held, black fill.
    clear_counts();
    s_drawReq = 1; clearReq = 1; drawSel = 5'd2;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (cyc == 13) s_drawReq = 0;
      if (s_busy) check("small_black", s_black, 1);
    end
    check("small_first_done", s_first_done, 11);
    check("small_second_done", s_last_done, 23);
    check("small_done_count", s_ndone, 2);
    check("small_plots", s_nplot, 16);

    // Full screen, no stalls, screenDone returned in FLUSH.
    clear_counts();
    drawReq = 1; drawSel = 5'd5; clearReq = 0; hold = 0;
    tick();
    drawReq = 0; drawSel = 5'd0;
    check("t1_init_xReset", xReset, 1);
    for (int i = 0; i < NPIX + 100 && n_done == 0; i++) begin
      screenDone = (m_tail == 2);
      tick();
    end
    screenDone = 0;
    check("t1_plots", n_plot, 19200);
    check("t1_first_load", first_load, 2);
    check("t1_first_plot", first_plot, 3);
    check("t1_done_cycle", done_cyc, 19203);
    check("t1_memorySel", memorySel, 5);
    check("t1_frameErr", frameErr, 0);

    // Random stalls, black fill, screenDone never returned.
    clear_counts();
    drawReq = 1; drawSel = 5'd17; clearReq = 1;
    tick();
    drawReq = 0;
    for (int i = 0; i < 45000 && n_done == 0; i++) begin
      hold = 1'($urandom_range(0, 1));
      tick();
    end
    hold = 0;
    check("t2_plots", n_plot, 19200);
    check("t2_yCountUp", n_y, 120);
    check("t2_x_plus_y", n_x + n_y, 19200);
    check("t2_frameErr", frameErr, 1);
    check("t2_black", black, 1);

    // Ignored request mid-draw, then asynchronous abort.
    clear_counts();
    drawReq = 1; drawSel = 5'd3; clearReq = 1;
    tick();
    drawReq = 0;
    check("t4_frameErr_cleared", frameErr, 0);
    while (cyc < 100) tick();
    drawReq = 1; drawSel = 5'd9; clearReq = 0;
    tick();
    drawReq = 0; drawSel = 5'd0;
    check("t4_sel_kept", memorySel, 3);
    check("t4_busy", busy, 1);
    while (cyc < 5000) tick();
    resetn = 0;
    #1;
    check("abort_busy",      busy,      0);
    check("abort_memorySel", memorySel, 0);
    check("abort_black",     black,     0);
    check("abort_plot",      plot,      0);
    check("abort_load",      scLoad,    0);
    model_reset();
    n_done = 0;
    tick();
    resetn = 1; drawReq = 1; drawSel = 5'd7;
    tick();
    drawReq = 0;
    check("resume_busy", busy, 1);
    check("resume_sel", memorySel, 7);
    for (int i = 0; i < 10; i++) tick();
    resetn = 0;
    model_reset();
    n_plot = 0;
    tick();
    resetn = 1;
    for (int i = 0; i < 30; i++) tick();
    check("abort_no_done", n_done, 0);
    check("abort_no_plot", n_plot, 0);
    check("abort_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter H_PIX, default 160, meaning pixels per row.
REQ-002 SHALL have parameter V_PIX, default 120, meaning rows per screen.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port drawReq  input  1  start a full-screen draw.
REQ-006 SHALL have port drawSel  input  5  screen ROM select, latched at acceptance.
REQ-007 SHALL have port clearReq  input  1  draw black instead of ROM data, latched at acceptance.
REQ-008 SHALL have port hold  input  1  stall pixel issue, for example while the VGA writer is busy.
REQ-009 SHALL have port screenDone  input  1  end-of-screen flag returned by the datapath xy counters.
REQ-010 SHALL have port memorySel  output  5  latched drawSel, driven to the datapath.
REQ-011 SHALL have port black  output  1  latched clearReq.
REQ-012 SHALL have port addressScreenCounterReset, xReset, yReset  output  1 each  counter clears.
REQ-013 SHALL have port screenCountLoad, xCountUp, yCountUp  output  1 each  counter advances.
REQ-014 SHALL have port plot  output  1  VGA write strobe for the current x, y and color.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port drawDone  output  1  single-cycle completion pulse.
REQ-017 SHALL have port frameErr  output  1  sticky flag: screenDone was not seen at end of frame.

Function
REQ-018 SHALL implement states IDLE, INIT, DRAW, FLUSH and DONE; the encoding is free.
REQ-019 IDLE: when drawReq=1, SHALL latch drawSel and clearReq, clear frameErr, and go to INIT on the next edge.
REQ-020 INIT (one cycle): SHALL assert addressScreenCounterReset, xReset and yReset, clear the internal pixel index p (15 bits) and column col (8 bits), then go to DRAW.
REQ-021 DRAW with hold=0: SHALL issue pixel p by asserting screenCountLoad=1.
- If col<H_PIX-1: SHALL assert xCountUp=1 and increment col.
- Otherwise: SHALL assert xReset=1 and yCountUp=1 and set col=0.
- SHALL increment p.
REQ-022 DRAW with hold=1: SHALL assert no counter output and leave p and col unchanged.
REQ-023 When pixel p=H_PIX*V_PIX-1 is issued, SHALL go to FLUSH on the next edge.
REQ-024 plot SHALL be a register equal to "a pixel was issued in the previous cycle", matching the one-cycle synchronous ROM read latency; hold has no further effect on plot.
REQ-025 FLUSH (one cycle): plot SHALL be 1 for the last pixel; if screenDone=0 in this cycle, SHALL set frameErr=1; then go to DONE.
REQ-026 DONE (one cycle): SHALL assert drawDone=1, then go to IDLE.
REQ-027 drawReq while busy=1 SHALL be ignored, and memorySel and black SHALL NOT change while busy=1.
REQ-028 drawReq held high in IDLE SHALL start a new draw; a draw accepted on the cycle after DONE is legal back-to-back operation.
REQ-029 Exactly H_PIX*V_PIX plot pulses SHALL occur per draw, with no duplicate or skipped pixels, for any hold pattern.
REQ-030 Timing with hold=0 throughout, drawReq sampled at edge 0:
- INIT at cycle 1;
- DRAW over cycles 2..19201;
- plot high over cycles 3..19202;
- FLUSH at cycle 19202;
- drawDone at cycle 19203.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE and drive every output to 0: memorySel=0, black=0, all strobes 0, plot=0, busy=0, drawDone=0, frameErr=0.
REQ-032 Reset asserted mid-draw SHALL abort the draw with no further plot pulse and no drawDone; operation resumes from IDLE on the first edge after resetn=1.

Verification
REQ-033 Directed test: drawSel=5, clearReq=0, hold=0, screenDone pulsed in FLUSH -> memorySel=5, 19200 plot pulses, drawDone at cycle 19203, frameErr=0.
REQ-034 Directed test: hold random at 50% duty -> still exactly 19200 plots and 120 yCountUp pulses, and xCountUp+yCountUp=19200.
REQ-035 Directed test: screenDone held at 0 -> frameErr=1 after the draw; the next accepted drawReq clears it.
REQ-036 Directed test: drawReq=1, drawSel=9 at cycle 100 of a draw of screen 3 -> ignored, memorySel stays 3.
REQ-037 Directed test: resetn pulsed low at cycle 5000 -> all outputs 0 asynchronously, IDLE afterwards, no drawDone.
REQ-038 Directed test: clearReq=1 -> black=1 for the whole draw; H_PIX=4, V_PIX=2 -> 8 plots, drawDone at cycle 11.
